// File: rtl/dac_sample_packer.sv
// dac_sample_packer
//   Packs a framed byte stream into 32-bit I/Q words for the dac_tx sample FIFO.
//   Byte 0 of each group of four lands in [31:24] and byte 3 in [7:0], so I = [31:16]
//   and Q = [15:0]. Input is throttled by FIFO watermarks with hysteresis. Words that
//   complete while the FIFO is full are dropped and counted as overflows. Frames whose
//   length is not a multiple of 4 are counted as framing errors.
// Ports:
//   clk, reset (async, active high), enable
//   rx_data/rx_valid/rx_sof/rx_eof/rx_ready : byte input with framing
//   data_we/data_out                         : FIFO write port (to dac_tx)
//   fifo_data_cnt/fifo_full                  : FIFO status
//   throttled, words_written, overflow_cnt, frame_err_cnt : status/counters
module dac_sample_packer #(
    parameter logic [15:0] HIGH_WATER = 16'd30720,
    parameter logic [15:0] LOW_WATER  = 16'd28672
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic        rx_ready,
    output logic        data_we,
    output logic [31:0] data_out,
    input  logic [15:0] fifo_data_cnt,
    input  logic        fifo_full,
    output logic        throttled,
    output logic [31:0] words_written,
    output logic [15:0] overflow_cnt,
    output logic [15:0] frame_err_cnt
);

    typedef enum logic {IDLE, PACK} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] part_q, part_d;        // bytes 0..2 of the word being assembled
    logic        enable_q, enable_d;
    logic        throttled_q, throttled_d;
    logic        data_we_q, data_we_d;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] words_q, words_d;
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] err_q, err_d;

    logic accept;
    logic issue;
    logic byte_err;

    assign rx_ready      = ~enable_q | ~throttled_q;
    assign data_we       = data_we_q;
    assign data_out      = data_out_q;
    assign throttled     = throttled_q;
    assign words_written = words_q;
    assign overflow_cnt  = ovf_q;
    assign frame_err_cnt = err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        part_d      = part_q;
        data_we_d   = 1'b0;
        data_out_d  = data_out_q;
        words_d     = words_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        issue       = 1'b0;
        byte_err    = 1'b0;
        enable_d    = enable;
        accept      = rx_valid & rx_ready & enable_q;

        if (!enable_q) begin
            // Disabled: bytes are swallowed and any partial word is dropped silently.
            state_d = IDLE;
            idx_d   = 2'd0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (rx_sof) begin
                        if (rx_eof) begin
                            byte_err = 1'b1;   // single-byte frame
                        end else begin
                            part_d[23:16] = rx_data;
                            idx_d         = 2'd1;
                            state_d       = PACK;
                        end
                    end
                end
                PACK: begin
                    if (rx_sof) begin
                        // Resync: an unfinished word is abandoned, the byte starts a new word.
                        byte_err = (idx_q != 2'd0) | rx_eof;
                        if (rx_eof) begin
                            idx_d   = 2'd0;
                            state_d = IDLE;
                        end else begin
                            part_d[23:16] = rx_data;
                            idx_d         = 2'd1;
                        end
                    end else begin
                        case (idx_q)
                            2'd0:    part_d[23:16] = rx_data;
                            2'd1:    part_d[15:8]  = rx_data;
                            2'd2:    part_d[7:0]   = rx_data;
                            default: issue         = 1'b1;
                        endcase
                        idx_d = idx_q + 2'd1;      // wraps 3 -> 0 after issue
                        if (rx_eof) begin
                            byte_err = (idx_q != 2'd3);
                            idx_d    = 2'd0;
                            state_d  = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end

        if (issue) begin
            if (!fifo_full) begin
                data_we_d  = 1'b1;
                data_out_d = {part_q, rx_data};
                words_d    = words_q + 32'd1;
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end

        if (byte_err && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end

        // Hysteresis: set at/above high water or full, release at/below low water.
        throttled_d = throttled_q;
        if (fifo_data_cnt >= HIGH_WATER || fifo_full) begin
            throttled_d = 1'b1;
        end else if (fifo_data_cnt <= LOW_WATER) begin
            throttled_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            part_q      <= 24'd0;
            enable_q    <= 1'b0;
            throttled_q <= 1'b0;
            data_we_q   <= 1'b0;
            data_out_q  <= 32'd0;
            words_q     <= 32'd0;
            ovf_q       <= 16'd0;
            err_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            part_q      <= part_d;
            enable_q    <= enable_d;
            throttled_q <= throttled_d;
            data_we_q   <= data_we_d;
            data_out_q  <= data_out_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_packer.sv
// Self-checking bench for dac_sample_packer: a directed vector table, hand-written
// corner sequences, then randomized traffic against a frame-level reference model.
module tb_dac_sample_packer;

    localparam logic [15:0] HW = 16'd30720;
    localparam logic [15:0] LW = 16'd28672;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof;
    logic        rx_ready;
    logic        data_we;
    logic [31:0] data_out;
    logic [15:0] fifo_data_cnt;
    logic        fifo_full;
    logic        throttled;
    logic [31:0] words_written;
    logic [15:0] overflow_cnt, frame_err_cnt;

    int total = 0;
    int bad   = 0;

    dac_sample_packer #(.HIGH_WATER(HW), .LOW_WATER(LW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_ready(rx_ready), .data_we(data_we), .data_out(data_out),
        .fifo_data_cnt(fifo_data_cnt), .fifo_full(fifo_full), .throttled(throttled),
        .words_written(words_written), .overflow_cnt(overflow_cnt),
        .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame level) ----------------
    bit          m_en, m_thr, m_in_frame, m_we;
    logic [7:0]  m_cur[$];          // bytes of the word currently being collected
    logic [31:0] m_out, m_ww;
    int          m_ovf, m_err;

    function automatic void model_reset();
        m_en = 0; m_thr = 0; m_in_frame = 0; m_we = 0;
        m_cur.delete();
        m_out = 0; m_ww = 0; m_ovf = 0; m_err = 0;
    endfunction

    // Evaluated with the pre-edge inputs and model state, i.e. what happens at the edge.
    function automatic void model_edge();
        bit acc, bad_frame;
        acc = rx_valid && (!m_en || !m_thr);
        m_we = 0;
        bad_frame = 0;
        if (m_en && acc) begin
            if (rx_sof) begin
                bad_frame = (m_cur.size() != 0);
                m_cur.delete();
                m_in_frame = 1;
            end
            if (m_in_frame) begin
                m_cur.push_back(rx_data);
                if (m_cur.size() == 4) begin
                    if (!fifo_full) begin
                        m_we  = 1;
                        m_out = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
                        m_ww  = m_ww + 1;
                    end else if (m_ovf < 16'hFFFF) begin
                        m_ovf++;
                    end
                    m_cur.delete();
                end
                if (rx_eof) begin
                    if (m_cur.size() != 0) bad_frame = 1;
                    m_cur.delete();
                    m_in_frame = 0;
                end
            end
            if (bad_frame && m_err < 16'hFFFF) m_err++;
        end
        if (!m_en) begin
            m_cur.delete();
            m_in_frame = 0;
        end
        if (fifo_data_cnt >= HW || fifo_full) m_thr = 1;
        else if (fifo_data_cnt <= LW) m_thr = 0;
        m_en = enable;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".we"},    {31'd0, data_we},       {31'd0, m_we});
        chk({tag, ".out"},   data_out,               m_out);
        chk({tag, ".ww"},    words_written,          m_ww);
        chk({tag, ".ovf"},   {16'd0, overflow_cnt},  m_ovf);
        chk({tag, ".err"},   {16'd0, frame_err_cnt}, m_err);
        chk({tag, ".thr"},   {31'd0, throttled},     {31'd0, m_thr});
        chk({tag, ".rdy"},   {31'd0, rx_ready},      {31'd0, (!m_en || !m_thr)});
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input bit v, input bit s, input bit e, input logic [7:0] d);
        rx_valid = v; rx_sof = s; rx_eof = e; rx_data = d;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        step(1, 1, 0, b0); step(1, 0, 0, b1); step(1, 0, 0, b2); step(1, 0, 1, b3);
    endtask

    typedef struct {
        bit          v, s, e;
        logic [7:0]  d;
        bit          we;
        logic [31:0] out;
        int          ww, err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 1, 0, 8'h01, 0, 32'h0,        0, 0};
        tbl[1]  = '{1, 0, 0, 8'h02, 0, 32'h0,        0, 0};
        tbl[2]  = '{1, 0, 0, 8'h03, 0, 32'h0,        0, 0};
        tbl[3]  = '{1, 0, 0, 8'h04, 1, 32'h01020304, 1, 0};
        tbl[4]  = '{1, 0, 0, 8'h05, 0, 32'h01020304, 1, 0};
        tbl[5]  = '{1, 0, 0, 8'h06, 0, 32'h01020304, 1, 0};
        tbl[6]  = '{1, 0, 0, 8'h07, 0, 32'h01020304, 1, 0};
        tbl[7]  = '{1, 0, 1, 8'h08, 1, 32'h05060708, 2, 0};
        tbl[8]  = '{1, 1, 0, 8'h11, 0, 32'h05060708, 2, 0};
        tbl[9]  = '{1, 0, 0, 8'h12, 0, 32'h05060708, 2, 0};
        tbl[10] = '{1, 0, 0, 8'h13, 0, 32'h05060708, 2, 0};
        tbl[11] = '{1, 0, 0, 8'h14, 1, 32'h11121314, 3, 0};
        tbl[12] = '{1, 0, 0, 8'h15, 0, 32'h11121314, 3, 0};
        tbl[13] = '{1, 0, 1, 8'h16, 0, 32'h11121314, 3, 1};

        reset = 1; enable = 0; rx_data = 0; rx_valid = 0; rx_sof = 0; rx_eof = 0;
        fifo_data_cnt = 0; fifo_full = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy", {31'd0, rx_ready}, 32'd1);
        chk("rst.we",  {31'd0, data_we},  32'd0);
        chk("rst.out", data_out, 32'd0);
        chk("rst.thr", {31'd0, throttled}, 32'd0);
        chk("rst.cnt", words_written | {16'd0, overflow_cnt} | {16'd0, frame_err_cnt}, 32'd0);
        reset = 0;

        // Directed table: basic packing then a 6-byte (short) frame.
        enable = 1;
        step(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
            chk($sformatf("tbl%0d.we", i),  {31'd0, data_we}, {31'd0, tbl[i].we});
            chk($sformatf("tbl%0d.out", i), data_out, tbl[i].out);
            chk($sformatf("tbl%0d.ww", i),  words_written, tbl[i].ww);
            chk($sformatf("tbl%0d.err", i), {16'd0, frame_err_cnt}, tbl[i].err);
        end
        step(1, 0, 0, 8'h17);      // trailing byte in IDLE: no write
        chk("tail.we", {31'd0, data_we}, 32'd0);

        // Throttle hysteresis.
        fifo_data_cnt = 16'd30720; step(0, 0, 0, 0);
        chk("thr.set",  {31'd0, throttled}, 32'd1);
        chk("thr.rdy",  {31'd0, rx_ready},  32'd0);
        fifo_data_cnt = 16'd29000; step(0, 0, 0, 0);
        chk("thr.hold", {31'd0, throttled}, 32'd1);
        fifo_data_cnt = 16'd28672; step(0, 0, 0, 0);
        chk("thr.clr",  {31'd0, throttled}, 32'd0);
        chk("thr.rdy1", {31'd0, rx_ready},  32'd1);
        fifo_data_cnt = 0;

        // Overflow: FIFO full while the 4th byte is accepted.
        step(1, 1, 0, 8'hA0); step(1, 0, 0, 8'hA1); step(1, 0, 0, 8'hA2);
        fifo_full = 1; step(1, 0, 1, 8'hA3);
        chk("ovf.we",  {31'd0, data_we}, 32'd0);
        chk("ovf.cnt", {16'd0, overflow_cnt}, 32'd1);
        chk("ovf.ww",  words_written, 32'd3);
        fifo_full = 0; step(0, 0, 0, 0);
        chk_model("ovf");

        // Sync loss: stray bytes in IDLE, then a restart after two bytes.
        step(1, 0, 0, 8'h55); step(1, 0, 0, 8'h66);
        chk("sync.idle_we", {31'd0, data_we}, 32'd0);
        step(1, 1, 0, 8'h21); step(1, 0, 0, 8'h22);
        frame4(8'h31, 8'h32, 8'h33, 8'h34);
        chk("sync.out", data_out, 32'h31323334);
        chk("sync.err", {16'd0, frame_err_cnt}, 32'd2);
        chk_model("sync");

        // Enable drop mid-frame, then recovery.
        step(1, 1, 0, 8'h41); step(1, 0, 0, 8'h42); step(1, 0, 0, 8'h43);
        enable = 0; step(0, 0, 0, 0);
        chk("dis.rdy", {31'd0, rx_ready}, 32'd1);
        step(1, 0, 0, 8'h44);
        chk("dis.we",  {31'd0, data_we}, 32'd0);
        chk("dis.err", {16'd0, frame_err_cnt}, 32'd2);
        enable = 1; step(0, 0, 0, 0);
        frame4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        chk("ren.out", data_out, 32'hB1B2B3B4);
        chk("ren.we",  {31'd0, data_we}, 32'd1);
        chk_model("ren");

        // Async reset mid-word, checked before the next edge.
        step(1, 1, 0, 8'hC1); step(1, 0, 0, 8'hC2);
        #2 reset = 1;
        #1;
        chk("arst.out", data_out, 32'd0);
        chk("arst.cnt", words_written | {16'd0, frame_err_cnt}, 32'd0);
        chk("arst.rdy", {31'd0, rx_ready}, 32'd1);
        model_reset();
        @(posedge clk); #1; reset = 0;
        enable = 1; step(0, 0, 0, 0);
        frame4(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        chk("arst.pack", data_out, 32'hD1D2D3D4);
        chk_model("arst");

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: fifo_data_cnt = 16'd0;
                    1: fifo_data_cnt = LW;
                    2: fifo_data_cnt = 16'd29000;
                    3: fifo_data_cnt = HW;
                    4: fifo_data_cnt = 16'd32000;
                    default: fifo_data_cnt = 16'($urandom);
                endcase
            end
            fifo_full = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, 8'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_sample_packer.md
# dac_sample_packer

Byte-stream to DAC-sample packer sitting directly upstream of `dac_tx`. It accepts framed bytes from the host receive path and assembles each group of four into one 32-bit I/Q word. Each word is written into the `dac_tx` sample FIFO through its `data_we`/`data_in` port. Flow control is watermark-based, using the FIFO's `fifo_data_cnt`/`fifo_full` status, with hysteresis, overflow and framing-error accounting.

## Interface
- `HIGH_WATER`, default 16'd30720: `fifo_data_cnt` level at or above which input is throttled.
- `LOW_WATER`, default 16'd28672: `fifo_data_cnt` level at or below which throttling releases. Must be < `HIGH_WATER`.

Ports:
- `clk`  in  1  write-side system clock; same clock as the `dac_tx` `clk` port.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  packer enable.
- `rx_data`  in  8  input byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_sof`  in  1  marks the first byte of a frame; qualified by `rx_valid`.
- `rx_eof`  in  1  marks the last byte of a frame; qualified by `rx_valid`.
- `rx_ready`  out  1  byte accepted at an edge where `rx_valid && rx_ready`.
- `data_we`  out  1  FIFO write strobe, one-cycle pulse; drives `dac_tx` `data_we`.
- `data_out`  out  32  packed sample; [31:16] = I (sent first), [15:0] = Q; drives `dac_tx` `data_in`.
- `fifo_data_cnt`  in  16  FIFO write-side fill level.
- `fifo_full`  in  1  FIFO full.
- `throttled`  out  1  watermark throttle state.
- `words_written`  out  32  words written; wraps modulo 2^32.
- `overflow_cnt`  out  16  words dropped because the FIFO was full; saturates at 16'hFFFF.
- `frame_err_cnt`  out  16  frames with length not a multiple of 4; saturates at 16'hFFFF.

## Operation
- **Enable sampling:** `enable` is registered into `enable_q`; all logic uses `enable_q`.
- **Ready:** `rx_ready = ~enable_q | ~throttled`, driven only from flops.
  - While `enable_q` = 0, bytes are accepted and discarded.
- **State machine IDLE / PACK**, with a byte index `idx[1:0]`.
  - IDLE: an accepted byte without `rx_sof` is discarded. An accepted byte with `rx_sof` is stored at index 0; `idx`←1; go to PACK.
  - PACK: each accepted byte is stored at `idx`.
    - Index 0 → `data_out[31:24]`, 1 → [23:16], 2 → [15:8], 3 → [7:0].
    - Completing index 3 issues a word and sets `idx`←0.
  - `rx_sof` while in PACK with `idx` ≠ 0: the partial word is dropped, `frame_err_cnt`++, and the byte restarts at index 0.
  - `rx_eof` on index 3: the word is issued; go to IDLE.
  - `rx_eof` on any other index: the partial word is dropped, `frame_err_cnt`++; go to IDLE.
  - `rx_sof` and `rx_eof` on the same byte: counts as an error (single-byte frame); go to IDLE.
- **Word issue:**
  - If `fifo_full` = 0 at the completing edge: `data_we` pulses and `words_written`++.
  - Otherwise: no write and `overflow_cnt`++. `data_we` is never asserted when `fifo_full` was high at the issuing edge.
- **Throttle:**
  - `throttled` sets when `fifo_data_cnt >= HIGH_WATER` or `fifo_full`.
  - `throttled` clears when `fifo_data_cnt <= LOW_WATER` and `!fifo_full`.
  - Otherwise it holds.
- **`enable_q` 1→0:** state→IDLE, `idx`←0, partial word dropped silently (no error count). Counters hold.
- **Reset:** all state returns to its reset value immediately; a partial word is lost uncounted.

## Timing
- **Reset values:**
  - `rx_ready` = 1 (`enable_q` = 0), `throttled` = 0.
  - `data_we` = 0, `data_out` = 0.
  - All counters = 0; state IDLE, `idx` = 0.
- **Word latency:** 4th byte accepted at edge N → `data_we` = 1 with valid `data_out` during cycle N→N+1. `data_out` holds until the next word.
- **Throughput:** 1 byte/clk sustained, so at most one `data_we` every 4 cycles.
- **Throttle latency:** `throttled` updates one edge after the watermark condition; `rx_ready` follows combinationally from the flop.
  - At most 1 byte is accepted after the condition appears, which is covered by the FIFO headroom above `HIGH_WATER`.
- **Counter updates:** all counters update at the same edge that `data_we` would rise.
  - An error and a word issue cannot coincide, since a single byte either completes a word or is flagged as an error.
- **Saturation:** saturated counters stay at FFFF until reset.

## Test plan
- **Basic packing:** `enable` = 1; 8-byte frame 01..08 with `rx_sof` on byte 1 and `rx_eof` on byte 8 → two `data_we` pulses with 32'h01020304 then 32'h05060708; `words_written` = 2; back in IDLE.
- **Short frame:** 6-byte frame → one word written; `frame_err_cnt` = 1; the 2 trailing bytes produce no write.
- **Throttle hysteresis:** drive `fifo_data_cnt` to 30720 → `throttled`=1 and `rx_ready`=0 by the next edge. Lower to 29000 → stays throttled. Lower to 28672 → released.
- **Overflow:** `fifo_full` = 1 while the 4th byte is accepted → `data_we` stays 0; `overflow_cnt` = 1; `words_written` unchanged.
- **Sync loss:** bytes without `rx_sof` in IDLE → no writes. `rx_sof` after 2 bytes of a frame → `frame_err_cnt`++, and the new frame packs correctly from its first byte.
- **Enable/reset mid-frame:** drop `enable` after 3 bytes → `rx_ready` = 1, no write, no error. Re-enable and send a new frame → correct packing. Assert `reset` mid-word → all outputs return to their reset values asynchronously.
